piso_serial_tx: RTL

Parallel-in, serial-out transmitter that sends a framed word one bit at a time on a single line, at a programmable bit period. It drives the serial input of the team's posedge-capture receive chain: the chain's `D` input samples `sout` and its `clk` is clocked by the same `clk`. The parallel side uses a valid/ready handshake. The block holds one word, and exactly one frame is in flight at a time.

---
 rtl/serial_pkg.sv | 21 ++
 rtl/piso_serial_tx_if.sv | 14 +
 rtl/piso_serial_tx_bit_timer.sv | 32 +++
 rtl/piso_serial_tx.sv | 122 ++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit chain: state encoding, line levels
// and counter sizing. The PARITY state always exists here, even when unused.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Counter width for a count range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serial_tx_if.sv
// Parallel-side valid/ready handshake of the serial transmitter.
// The producer uses the master modport, the transmitter the slave modport.
interface piso_serial_tx_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);

endinterface

// File: rtl/piso_serial_tx_bit_timer.sv
// Bit-period timer: counts clock cycles within one serial bit and flags the
// final cycle of each bit. The count is parked at zero whenever run is low.
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int             CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (!run || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // With one clock per bit the count sits at LAST, so tick is high every cycle.
  assign tick = (count == LAST);

endmodule

// File: rtl/piso_serial_tx.sv
// Framed parallel-in serial-out transmitter (start, WIDTH data bits LSB first,
// stop). Defining PISO_SERIAL_TX_PARITY_EN inserts an even-parity bit before stop.
module piso_serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  piso_serial_tx_if.slave       bus,
  output logic                  sout,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_START  = 3'(START);
  localparam logic [2:0] ST_DATA   = 3'(DATA);
`ifdef PISO_SERIAL_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'(PARITY);
`endif
  localparam logic [2:0] ST_STOP   = 3'(STOP);

  localparam int            BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bitcnt;
  logic             tick;
  logic             handshake;
  logic             data_tick;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .clr  (clr),
    .run  (busy),
    .tick (tick)
  );

  assign bus.din_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_STOP) && tick;
  assign handshake     = bus.din_valid && bus.din_ready;
  assign data_tick     = (state == ST_DATA) && tick;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (handshake) state_nx = ST_START;
      ST_START:  if (tick)      state_nx = ST_DATA;
      ST_DATA: begin
        if (tick && bitcnt == LAST_BIT) begin
`ifdef PISO_SERIAL_TX_PARITY_EN
          state_nx = ST_PARITY;
`else
          state_nx = ST_STOP;
`endif
        end
      end
`ifdef PISO_SERIAL_TX_PARITY_EN
      ST_PARITY: if (tick)      state_nx = ST_STOP;
`endif
      ST_STOP:   if (tick)      state_nx = ST_IDLE;
      default:                  state_nx = ST_IDLE;
    endcase
  end

  // The bit counter wraps to zero on the last data tick, which is also the
  // edge that leaves DATA, so it is always clear outside DATA.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      bitcnt <= '0;
    end else begin
      state <= state_nx;
      if (handshake) begin
        shreg <= bus.din;
      end else if (data_tick) begin
        shreg <= shreg >> 1;
      end
      if (data_tick) begin
        bitcnt <= (bitcnt == LAST_BIT) ? '0 : bitcnt + 1'b1;
      end
    end
  end

`ifdef PISO_SERIAL_TX_PARITY_EN
  logic parity;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      parity <= 1'b0;
    end else if (handshake) begin
      parity <= ^bus.din;
    end
  end
`endif

  // The line level is registered from the current state, so each bit appears
  // one edge after its state is entered and the stop level carries into IDLE.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sout <= LINE_IDLE;
    end else begin
      case (state)
        ST_START:  sout <= LINE_START;
        ST_DATA:   sout <= shreg[0];
`ifdef PISO_SERIAL_TX_PARITY_EN
        ST_PARITY: sout <= parity;
`endif
        default:   sout <= LINE_IDLE;
      endcase
    end
  end

endmodule
